mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Multicycle control FSM directly downstream of the instruction register.
- Consumes the latched instruction's opcode and the ALU Zero flag.
- Sequences IF/ID/EXE/MEM/WB and drives every datapath control line, including IRWre, which is the load enable of the instruction register.

Parameters:
- OPW, 6, opcode width (instruction[31:26]).

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- opcode  in  OPW  instruction register output [31:26].
- Zero  in  1  ALU result==0.
- PCWre  out  1  PC load enable.
- IRWre  out  1  instruction register load enable.
- InsMemRW  out  1  1=read instruction memory.
- ALUSrcA  out  1  0=rs, 1=sa.
- ALUSrcB  out  1  0=rt, 1=extended imm.
- ALUOp  out  3  000 add, 001 sub, 010 B<<A, 011 or, 100 and, 101 unsigned lt, 110 signed lt.
- ExtSel  out  1  0=zero-extend, 1=sign-extend.
- RegWre  out  1  register file write.
- RegDst  out  2  00 $31, 01 rt, 10 rd.
- WrRegDSrc  out  1  0=PC+4, 1=DB.
- DBDataSrc  out  1  0=ALU, 1=data memory.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- PCSrc  out  2  00 PC+4, 01 PC+4+(imm<<2), 10 rs, 11 jump target.
- state_o  out  4  current state, debug only.

Behaviour:
Opcodes:
- add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sltiu 100111.
- sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
- Every other opcode is a nop.

State register and reset:
- State register updates on posedge CLK only.
- RST=1 at an edge puts the FSM in sIF regardless of the current state; a mid-instruction RST aborts the instruction.
- While RST=1, all outputs are combinationally forced to 0: PCWre, IRWre, RegWre, mWR, mRD, InsMemRW, and every select.

Outputs:
- Outputs are combinational from (state, opcode, Zero), Moore-style except PCSrc in sEXE_BR.
- Any signal not listed for a state is 0.

Sequences (one state per cycle):
- ALU ops: sIF→sID→sEXE_AL→sWB_AL (4 cycles).
- beq: sIF→sID→sEXE_BR (3 cycles).
- sw: sIF→sID→sEXE_LS→sMEM (4 cycles).
- lw: sIF→sID→sEXE_LS→sMEM→sWB_LD (5 cycles).
- j, jal, jr, nop: sIF→sID (2 cycles).
- halt: sIF→sID→sHALT; sHALT is absorbing until RST, with all enables 0.

Per-state outputs:
- sIF: InsMemRW=1, IRWre=1 (the instruction register captures the word at the edge leaving sIF).
- sID, j: PCWre=1, PCSrc=11.
- sID, jr: PCWre=1, PCSrc=10.
- sID, jal: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
- sID, nop: PCWre=1, PCSrc=00.
- sEXE_AL: ALUOp per opcode.
  - ALUSrcB=1 for addi/ori/sltiu.
  - ALUSrcA=1 for sll.
  - ExtSel=0 for ori only.
- sWB_AL: the sEXE_AL selects held, plus RegWre=1, WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=00.
  - RegDst=10 for R-type (add, sub, or, and, sll, slt); 01 for immediates.
- sEXE_BR: ALUOp=001, ALUSrcB=0, ExtSel=1, PCWre=1, PCSrc = Zero ? 01 : 00. Zero is sampled in the same cycle.
- sEXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1.
- sMEM: the sEXE_LS selects held.
  - lw: mRD=1.
  - sw: mWR=1, PCWre=1, PCSrc=00.
- sWB_LD: mRD=1, DBDataSrc=1, WrRegDSrc=1, RegDst=01, RegWre=1, PCWre=1, PCSrc=00.

Invariants:
- PCWre is asserted exactly once per instruction, in its final state.
- IRWre is asserted only in sIF.
- The FSM never enters an undefined encoding; an unknown state goes to sIF.

Decomposition:
- Package mc_ctrl_pkg holds:
  - State encodings: sIF=0000, sID=0001, sEXE_AL=0010, sWB_AL=0011, sEXE_BR=0100, sEXE_LS=0101, sMEM=0110, sWB_LD=0111, sHALT=1000.
  - Opcode constants.
  - ALUOp, PCSrc and RegDst codes.
- One sub-module, mc_ctrl_decode: purely combinational (state, opcode, Zero)→outputs. The top holds only the state register and next-state logic.

Test Plan:
- RST=1 two cycles, then opcode=000000 (add) → states IF,ID,EXE_AL,WB_AL; in WB_AL RegWre=1, RegDst=10, PCWre=1; IRWre=1 only in IF.
- lw (110001) → 5 states; mRD=1 in MEM and WB_LD, RegWre=1 only in WB_LD, RegDst=01, DBDataSrc=1.
- beq with Zero=1 → EXE_BR has PCSrc=01 and PCWre=1; repeat with Zero=0 → PCSrc=00; next state IF in both cases.
- jal (111010) → ID has RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1; next state IF. jr → ID has PCSrc=10.
- halt (111111) → state reaches 1000 and stays there 20 cycles with PCWre=IRWre=RegWre=mWR=0; RST=1 → IF.
- sw with RST asserted during MEM → mWR=0 in that cycle; next state IF; opcode 101010 (undefined) → 2-cycle nop with PCSrc=00.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state encodings, opcodes, select codes and control bundle
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    sIF     = 4'b0000,
    sID     = 4'b0001,
    sEXE_AL = 4'b0010,
    sWB_AL  = 4'b0011,
    sEXE_BR = 4'b0100,
    sEXE_LS = 4'b0101,
    sMEM    = 4'b0110,
    sWB_LD  = 4'b0111,
    sHALT   = 4'b1000
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTIU = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_LTU  = 3'b101;
  localparam logic [2:0] ALU_LTS  = 3'b110;

  localparam logic [1:0] PCSRC_PC4  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_RS   = 2'b10;
  localparam logic [1:0] PCSRC_JUMP = 2'b11;

  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       ins_mem_rw;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       ext_sel;
    logic       reg_wre;
    logic [1:0] reg_dst;
    logic       wr_reg_d_src;
    logic       db_data_src;
    logic       m_rd;
    logic       m_wr;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic is_alu(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT, OP_SLTIU};
  endfunction

  function automatic logic is_imm(input logic [5:0] op);
    return op inside {OP_ADDI, OP_ORI, OP_SLTIU};
  endfunction

  function automatic logic [2:0] alu_op_for(input logic [5:0] op);
    case (op)
      OP_SUB:         return ALU_SUB;
      OP_OR, OP_ORI:  return ALU_OR;
      OP_AND:         return ALU_AND;
      OP_SLL:         return ALU_SLL;
      OP_SLT:         return ALU_LTS;
      OP_SLTIU:       return ALU_LTU;
      default:        return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational (state, opcode, Zero) to control lines
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  state_t         state_i,
  input  logic [OPW-1:0] opcode_i,
  input  logic           zero_i,
  output ctrl_t          ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      sIF: begin
        ctrl_o.ins_mem_rw = 1'b1;
        ctrl_o.ir_wre     = 1'b1;
      end
      sID: begin
        case (opcode_i)
          OP_J: begin
            ctrl_o.pc_wre = 1'b1;
            ctrl_o.pc_src = PCSRC_JUMP;
          end
          OP_JR: begin
            ctrl_o.pc_wre = 1'b1;
            ctrl_o.pc_src = PCSRC_RS;
          end
          OP_JAL: begin
            ctrl_o.pc_wre       = 1'b1;
            ctrl_o.pc_src       = PCSRC_JUMP;
            ctrl_o.reg_wre      = 1'b1;
            ctrl_o.reg_dst      = REGDST_RA;
            ctrl_o.wr_reg_d_src = 1'b0;
          end
          OP_BEQ, OP_SW, OP_LW, OP_HALT: ;
          default: begin
            // Anything not continuing past ID is a nop and retires here.
            if (!is_alu(opcode_i)) begin
              ctrl_o.pc_wre = 1'b1;
              ctrl_o.pc_src = PCSRC_PC4;
            end
          end
        endcase
      end
      sEXE_AL, sWB_AL: begin
        ctrl_o.alu_op    = alu_op_for(opcode_i);
        ctrl_o.alu_src_b = is_imm(opcode_i);
        ctrl_o.alu_src_a = (opcode_i == OP_SLL);
        ctrl_o.ext_sel   = (opcode_i != OP_ORI);
        if (state_i == sWB_AL) begin
          ctrl_o.reg_wre      = 1'b1;
          ctrl_o.wr_reg_d_src = 1'b1;
          ctrl_o.db_data_src  = 1'b0;
          ctrl_o.pc_wre       = 1'b1;
          ctrl_o.pc_src       = PCSRC_PC4;
          ctrl_o.reg_dst      = is_imm(opcode_i) ? REGDST_RT : REGDST_RD;
        end
      end
      sEXE_BR: begin
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.alu_src_b = 1'b0;
        ctrl_o.ext_sel   = 1'b1;
        ctrl_o.pc_wre    = 1'b1;
        ctrl_o.pc_src    = zero_i ? PCSRC_BR : PCSRC_PC4;
      end
      sEXE_LS, sMEM: begin
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.alu_src_b = 1'b1;
        ctrl_o.ext_sel   = 1'b1;
        if (state_i == sMEM) begin
          if (opcode_i == OP_LW) begin
            ctrl_o.m_rd = 1'b1;
          end else if (opcode_i == OP_SW) begin
            ctrl_o.m_wr   = 1'b1;
            ctrl_o.pc_wre = 1'b1;
            ctrl_o.pc_src = PCSRC_PC4;
          end
        end
      end
      sWB_LD: begin
        ctrl_o.m_rd         = 1'b1;
        ctrl_o.db_data_src  = 1'b1;
        ctrl_o.wr_reg_d_src = 1'b1;
        ctrl_o.reg_dst      = REGDST_RT;
        ctrl_o.reg_wre      = 1'b1;
        ctrl_o.pc_wre       = 1'b1;
        ctrl_o.pc_src       = PCSRC_PC4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle control FSM: state register and next-state logic
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] opcode,
  input  logic           Zero,
  output logic           PCWre,
  output logic           IRWre,
  output logic           InsMemRW,
  output logic           ALUSrcA,
  output logic           ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic           ExtSel,
  output logic           RegWre,
  output logic [1:0]     RegDst,
  output logic           WrRegDSrc,
  output logic           DBDataSrc,
  output logic           mRD,
  output logic           mWR,
  output logic [1:0]     PCSrc,
  output logic [3:0]     state_o
);

  state_t state_q, state_d;
  ctrl_t  dec, ctrl;

  always_comb begin
    state_d = sIF;
    case (state_q)
      sIF:     state_d = sID;
      sID: begin
        if (is_alu(opcode)) begin
          state_d = sEXE_AL;
        end else begin
          case (opcode)
            OP_BEQ:       state_d = sEXE_BR;
            OP_SW, OP_LW: state_d = sEXE_LS;
            OP_HALT:      state_d = sHALT;
            default:      state_d = sIF;
          endcase
        end
      end
      sEXE_AL: state_d = sWB_AL;
      sEXE_LS: state_d = sMEM;
      sMEM:    state_d = (opcode == OP_LW) ? sWB_LD : sIF;
      sHALT:   state_d = sHALT;
      default: state_d = sIF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= sIF;
    else     state_q <= state_d;
  end

  mc_ctrl_decode #(.OPW(OPW)) u_decode (
    .state_i  (state_q),
    .opcode_i (opcode),
    .zero_i   (Zero),
    .ctrl_o   (dec)
  );

  // Reset kills every enable and select immediately, including mid-instruction.
  assign ctrl = RST ? '0 : dec;

  assign PCWre     = ctrl.pc_wre;
  assign IRWre     = ctrl.ir_wre;
  assign InsMemRW  = ctrl.ins_mem_rw;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign ExtSel    = ctrl.ext_sel;
  assign RegWre    = ctrl.reg_wre;
  assign RegDst    = ctrl.reg_dst;
  assign WrRegDSrc = ctrl.wr_reg_d_src;
  assign DBDataSrc = ctrl.db_data_src;
  assign mRD       = ctrl.m_rd;
  assign mWR       = ctrl.m_wr;
  assign PCSrc     = ctrl.pc_src;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - directed-vector bench for mc_control_unit
module tb_mc_control_unit;

  logic       CLK, RST, Zero;
  logic [5:0] opcode;
  logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, RegWre;
  logic       WrRegDSrc, DBDataSrc, mRD, mWR;
  logic [2:0] ALUOp;
  logic [1:0] RegDst, PCSrc;
  logic [3:0] state_o;

  int n_chk = 0;
  int n_fail = 0;

  mc_control_unit #(.OPW(6)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .Zero(Zero),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
    .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
    .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc),
    .state_o(state_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Field order: PCWre IRWre InsMemRW SrcA SrcB ALUOp ExtSel RegWre RegDst WrRegDSrc DBDataSrc mRD mWR PCSrc
  logic [17:0] obs;
  assign obs = {PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp, ExtSel, RegWre,
                RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc};

  localparam logic [17:0] V_ZERO = 18'b0_0_0_0_0_000_0_0_00_0_0_0_0_00;
  localparam logic [17:0] V_IF   = 18'b0_1_1_0_0_000_0_0_00_0_0_0_0_00;
  localparam logic [17:0] ADD_EX = 18'b0_0_0_0_0_000_1_0_00_0_0_0_0_00;
  localparam logic [17:0] ADD_WB = 18'b1_0_0_0_0_000_1_1_10_1_0_0_0_00;
  localparam logic [17:0] ORI_EX = 18'b0_0_0_0_1_011_0_0_00_0_0_0_0_00;
  localparam logic [17:0] ORI_WB = 18'b1_0_0_0_1_011_0_1_01_1_0_0_0_00;
  localparam logic [17:0] LS_EX  = 18'b0_0_0_0_1_000_1_0_00_0_0_0_0_00;
  localparam logic [17:0] LW_MEM = 18'b0_0_0_0_1_000_1_0_00_0_0_1_0_00;
  localparam logic [17:0] LW_WB  = 18'b1_0_0_0_0_000_0_1_01_1_1_1_0_00;
  localparam logic [17:0] SW_MEM = 18'b1_0_0_0_1_000_1_0_00_0_0_0_1_00;
  localparam logic [17:0] BEQ_T  = 18'b1_0_0_0_0_001_1_0_00_0_0_0_0_01;
  localparam logic [17:0] BEQ_N  = 18'b1_0_0_0_0_001_1_0_00_0_0_0_0_00;
  localparam logic [17:0] JAL_ID = 18'b1_0_0_0_0_000_0_1_00_0_0_0_0_11;
  localparam logic [17:0] JR_ID  = 18'b1_0_0_0_0_000_0_0_00_0_0_0_0_10;
  localparam logic [17:0] NOP_ID = 18'b1_0_0_0_0_000_0_0_00_0_0_0_0_00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_st(input string tag, input logic [3:0] st, input logic [17:0] v);
    check_eq({tag, ".state"}, 32'(state_o), 32'(st));
    check_eq({tag, ".ctl"}, 32'(obs), 32'(v));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; opcode = 6'b000000; Zero = 1'b0;
    step(); step();
    expect_st("rst", 4'd0, V_ZERO);
    RST = 1'b0; #1;

    // add: IF ID EXE_AL WB_AL
    expect_st("add.if", 4'd0, V_IF);
    step(); expect_st("add.id",  4'd1, V_ZERO);
    step(); expect_st("add.exe", 4'd2, ADD_EX);
    step(); expect_st("add.wb",  4'd3, ADD_WB);

    step(); expect_st("ori.if", 4'd0, V_IF);
    opcode = 6'b010010;
    step(); expect_st("ori.id",  4'd1, V_ZERO);
    step(); expect_st("ori.exe", 4'd2, ORI_EX);
    step(); expect_st("ori.wb",  4'd3, ORI_WB);

    step(); expect_st("lw.if", 4'd0, V_IF);
    opcode = 6'b110001;
    step(); expect_st("lw.id",  4'd1, V_ZERO);
    step(); expect_st("lw.exe", 4'd5, LS_EX);
    step(); expect_st("lw.mem", 4'd6, LW_MEM);
    step(); expect_st("lw.wb",  4'd7, LW_WB);

    step(); expect_st("beq1.if", 4'd0, V_IF);
    opcode = 6'b110100; Zero = 1'b1;
    step(); expect_st("beq1.id", 4'd1, V_ZERO);
    step(); expect_st("beq1.br", 4'd4, BEQ_T);
    Zero = 1'b0; #1;
    expect_st("beq1.br_z0", 4'd4, BEQ_N);
    step(); expect_st("beq0.if", 4'd0, V_IF);
    step(); expect_st("beq0.id", 4'd1, V_ZERO);
    step(); expect_st("beq0.br", 4'd4, BEQ_N);

    step(); expect_st("jal.if", 4'd0, V_IF);
    opcode = 6'b111010;
    step(); expect_st("jal.id", 4'd1, JAL_ID);
    step(); expect_st("jr.if", 4'd0, V_IF);
    opcode = 6'b111001;
    step(); expect_st("jr.id", 4'd1, JR_ID);

    step(); expect_st("halt.if", 4'd0, V_IF);
    opcode = 6'b111111;
    step(); expect_st("halt.id", 4'd1, V_ZERO);
    for (int i = 0; i < 20; i++) begin
      step(); expect_st($sformatf("halt.c%0d", i), 4'd8, V_ZERO);
    end
    RST = 1'b1;
    step(); expect_st("halt.rst", 4'd0, V_ZERO);
    RST = 1'b0; #1;
    expect_st("sw.if", 4'd0, V_IF);

    // sw aborted by reset in MEM
    opcode = 6'b110000;
    step(); expect_st("sw.id",  4'd1, V_ZERO);
    step(); expect_st("sw.exe", 4'd5, LS_EX);
    step(); expect_st("sw.mem", 4'd6, SW_MEM);
    RST = 1'b1; #1;
    expect_st("sw.mem_rst", 4'd6, V_ZERO);
    step(); expect_st("sw.after_rst", 4'd0, V_ZERO);
    RST = 1'b0; #1;

    expect_st("nop.if", 4'd0, V_IF);
    opcode = 6'b101010;
    step(); expect_st("nop.id", 4'd1, NOP_ID);
    step(); expect_st("nop.next", 4'd0, V_IF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
